regfile_writeback_ctrl: RTL and testbench

//  Writer-side controller for the 32x32 register file's single write port.

---
 rtl/regfile_writeback_ctrl.sv | 134 +++++++++++++
 tb/tb_regfile_writeback_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_ctrl.sv
// rtl/regfile_writeback_ctrl.sv - single write-port arbiter for the 32x32 register file
// Loads take the port unconditionally; ALU results bypass when idle or queue in a small FIFO.
module regfile_writeback_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [ADDR_W-1:0]         mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  output logic                      regwrite,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic [31:0]               pending_mask,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic                 regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]    write_reg_q, write_reg_d;
  logic [DATA_W-1:0]    write_data_q, write_data_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [ADDR_W-1:0]    fifo_rd_q   [DEPTH];
  logic [DATA_W-1:0]    fifo_data_q [DEPTH];

  logic alu_accept;
  logic alu_live;
  logic mem_issue;
  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);
  assign alu_ready  = (count_q < DEPTH_C) || (alu_rd == '0);
  assign alu_accept = alu_valid && alu_ready;
  // rd == 0 requests are acknowledged but never written or queued
  assign alu_live   = alu_accept && (alu_rd != '0);
  assign mem_issue  = mem_valid && (mem_rd != '0);

  always_comb begin
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    push         = 1'b0;
    pop          = 1'b0;
    if (mem_issue) begin
      regwrite_d   = 1'b1;
      write_reg_d  = mem_rd;
      write_data_d = mem_data;
      push         = alu_live;
    end else if (!fifo_empty) begin
      regwrite_d   = 1'b1;
      write_reg_d  = fifo_rd_q[rd_ptr_q];
      write_data_d = fifo_data_q[rd_ptr_q];
      pop          = 1'b1;
      push         = alu_live;
    end else if (alu_live) begin
      regwrite_d   = 1'b1;
      write_reg_d  = alu_rd;
      write_data_d = alu_data;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    // push and pop never hit the same slot: push needs a free slot, pop an occupied one
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      if (push) begin
        fifo_rd_q[wr_ptr_q]   <= alu_rd;
        fifo_data_q[wr_ptr_q] <= alu_data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        pending_mask[fifo_rd_q[i]] = 1'b1;
      end
    end
  end

  assign regwrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// tb/tb_regfile_writeback_ctrl.sv - directed bench for regfile_writeback_ctrl
module tb_regfile_writeback_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  regfile_writeback_ctrl #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic drive_mem(input logic [4:0] rd, input logic [31:0] d);
    mem_valid = 1'b1; mem_rd = rd; mem_data = d;
    #0;
    chk("load_hazard", {63'd0, pending_mask[rd]}, 64'd0);
  endtask

  // expected order of ALU writes for the mixed-traffic run
  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];
  logic [31:0] exp_mask;
  logic        exp_ready;
  int          alu_n;
  logic [11:0] mem_pat;

  initial begin
    idle();
    tick();
    chk("rst_regwrite", regwrite, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_mask", pending_mask, 0);
    chk("rst_ready", alu_ready, 1);
    tick();
    reset = 1'b0;
    tick();

    // single ALU result bypasses the empty FIFO
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("t1_ready", alu_ready, 1);
    tick();
    idle();
    chk("t1_regwrite", regwrite, 1);
    chk("t1_reg", write_reg, 5);
    chk("t1_data", write_data, 32'hDEADBEEF);
    chk("t1_count", fifo_count, 0);
    tick();
    chk("t1_regwrite_off", regwrite, 0);
    chk("t1_reg_hold", write_reg, 5);
    chk("t1_data_hold", write_data, 32'hDEADBEEF);

    // load and ALU collide: load first, ALU queued one cycle
    drive_mem(5'd3, 32'h11);
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    tick();
    idle();
    chk("t2_reg0", write_reg, 3);
    chk("t2_data0", write_data, 32'h11);
    chk("t2_we0", regwrite, 1);
    chk("t2_mask", pending_mask, 32'h10);
    chk("t2_count", fifo_count, 1);
    tick();
    chk("t2_we1", regwrite, 1);
    chk("t2_reg1", write_reg, 4);
    chk("t2_data1", write_data, 32'h22);
    chk("t2_mask_clr", pending_mask, 0);
    chk("t2_count_clr", fifo_count, 0);
    tick();
    chk("t2_we_off", regwrite, 0);

    // loads hold the port for 6 cycles; FIFO fills to DEPTH and backpressures
    alu_n = 0;
    for (int k = 0; k < 6; k++) begin
      drive_mem(5'(8 + k), 32'h100 + k);
      alu_valid = 1'b1; alu_rd = 5'(16 + alu_n); alu_data = 32'h200 + alu_n;
      #1;
      chk("t3_ready", alu_ready, (k < 4) ? 1 : 0);
      if (k < 4) alu_n++;
      tick();
      chk("t3_mem_reg", write_reg, 8 + k);
      chk("t3_mem_data", write_data, 32'h100 + k);
      chk("t3_count", fifo_count, (k < 3) ? k + 1 : 4);
    end
    idle();
    alu_valid = 1'b1; alu_rd = 5'd0;
    #1;
    chk("t3_ready_rd0_full", alu_ready, 1);
    idle();
    chk("t3_mask_full", pending_mask, 32'h000F0000);
    for (int j = 0; j < 4; j++) begin
      tick();
      exp_mask = '0;
      for (int b = j + 1; b < 4; b++) exp_mask[16 + b] = 1'b1;
      chk("t3_drain_we", regwrite, 1);
      chk("t3_drain_reg", write_reg, 16 + j);
      chk("t3_drain_data", write_data, 32'h200 + j);
      chk("t3_drain_count", fifo_count, 3 - j);
      chk("t3_drain_mask", pending_mask, exp_mask);
    end
    tick();
    chk("t3_idle_we", regwrite, 0);

    // rd 0 on both paths is swallowed
    for (int k = 0; k < 5; k++) begin
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD0 + k;
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBAD8 + k;
      #1;
      chk("t4_ready", alu_ready, 1);
      tick();
      chk("t4_we", regwrite, 0);
      chk("t4_count", fifo_count, 0);
    end
    idle();

    // asynchronous reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      drive_mem(5'd9, 32'h99);
      alu_valid = 1'b1; alu_rd = 5'(21 + k); alu_data = 32'h300 + k;
      tick();
    end
    idle();
    chk("t5_pre_count", fifo_count, 3);
    chk("t5_pre_mask", pending_mask, 32'h00E00000);
    chk("t5_pre_we", regwrite, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_we", regwrite, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_mask", pending_mask, 0);
    chk("t5_reg", write_reg, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_no_write", regwrite, 0);
    end

    // mixed traffic across two pointer wraps against a queue model
    mem_pat = 12'b101010101010;
    alu_n = 0;
    for (int i = 0; i < 15; i++) begin
      idle();
      if (i < 12) begin
        if (mem_pat[11 - i]) drive_mem(5'(24 + (i % 4)), 32'hA000 + i);
        alu_valid = 1'b1; alu_rd = 5'(1 + alu_n); alu_data = 32'hB000 + alu_n;
      end
      #1;
      exp_ready = (q_rd.size() < 4);
      if (i < 12) chk("t6_ready", alu_ready, exp_ready);
      if (i < 12 && exp_ready) begin
        q_rd.push_back(5'(1 + alu_n));
        q_data.push_back(32'hB000 + alu_n);
        alu_n++;
      end
      tick();
      if (i < 12 && mem_pat[11 - i]) begin
        chk("t6_mem_reg", write_reg, 24 + (i % 4));
        chk("t6_mem_data", write_data, 32'hA000 + i);
      end else if (q_rd.size() > 0) begin
        chk("t6_alu_we", regwrite, 1);
        chk("t6_alu_reg", write_reg, q_rd.pop_front());
        chk("t6_alu_data", write_data, q_data.pop_front());
      end else begin
        chk("t6_idle_we", regwrite, 0);
      end
      exp_mask = '0;
      for (int b = 0; b < q_rd.size(); b++) exp_mask[q_rd[b]] = 1'b1;
      chk("t6_count", fifo_count, q_rd.size());
      chk("t6_mask", pending_mask, exp_mask);
    end
    idle();
    chk("t6_alu_total", alu_n, 9);
    tick();
    chk("t6_final_we", regwrite, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
